wb_victim_cache: RTL and testbench

- Parametrised, fully-associative victim cache placed beside the write-back data cache.
- Holds lines evicted from the dcache and serves them back on a dcache miss, so the refill avoids a memory round-trip.
- Dirty lines displaced from the victim cache, or drained by a flush, are written back over a req/ack memory port.
- Generalises the single-entry victim path to N entries, with round-robin replacement, dirty tracking and a flush drain.

---
 rtl/wb_victim_cache.sv | 295 +++++++++++++++++++++++++++++
 tb/tb_wb_victim_cache.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_victim_cache.sv
// wb_victim_cache
//   Fully-associative victim cache sitting beside the write-back dcache.
//   Lines evicted from the dcache are parked here and handed back on a
//   dcache miss. Dirty lines pushed out by round-robin replacement, or
//   drained by a flush, leave through a single-line write-back buffer on a
//   req/ack memory port.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   lookup_req_i/addr_i miss lookup strobe and address (offset ignored)
//   lookup_valid_o      one-cycle result pulse, one cycle after the request
//   lookup_hit_o/data_o/dirty_o  result of that lookup (data/dirty 0 on miss)
//   take_i              in the result cycle of a hit: invalidate that entry
//   insert_i/addr_i/data_i/dirty_i  evicted dcache line
//   insert_ready_o      insert accepted this cycle when high
//   flush_i             drain dirty entries, then invalidate everything
//   flush_done_o        one-cycle pulse when the flush has completed
//   wb_req_o/addr_o/data_o, wb_ack_i  write-back port (address line-aligned)
//
// Optional build macro
//   VC_STATS_EN  adds hit_cnt_o / miss_cnt_o saturating lookup counters,
//                cleared by reset and by flush_done_o.

module wb_victim_cache #(
  parameter int ADDR_W     = 32,
  parameter int LINE_W     = 128,
  parameter int VC_ENTRIES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              lookup_req_i,
  input  logic [ADDR_W-1:0] lookup_addr_i,
  output logic              lookup_valid_o,
  output logic              lookup_hit_o,
  output logic [LINE_W-1:0] lookup_data_o,
  output logic              lookup_dirty_o,
  input  logic              take_i,
  input  logic              insert_i,
  input  logic [ADDR_W-1:0] insert_addr_i,
  input  logic [LINE_W-1:0] insert_data_i,
  input  logic              insert_dirty_i,
  output logic              insert_ready_o,
  input  logic              flush_i,
  output logic              flush_done_o,
  output logic              wb_req_o,
  output logic [ADDR_W-1:0] wb_addr_o,
  output logic [LINE_W-1:0] wb_data_o,
  input  logic              wb_ack_i
`ifdef VC_STATS_EN
  ,
  output logic [31:0]       hit_cnt_o,
  output logic [31:0]       miss_cnt_o
`endif
);

  localparam int OFFSET_W = $clog2(LINE_W / 8);
  localparam int TAG_W    = ADDR_W - OFFSET_W;
  localparam int PTR_W    = $clog2(VC_ENTRIES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WB,
    S_FLUSH_SCAN,
    S_FLUSH_WB
  } state_e;

  state_e                  state_q, state_d;
  logic [VC_ENTRIES-1:0]   valid_q, valid_d;
  logic [VC_ENTRIES-1:0]   dirty_q, dirty_d;
  logic [TAG_W-1:0]        tag_q  [VC_ENTRIES];
  logic [TAG_W-1:0]        tag_d  [VC_ENTRIES];
  logic [LINE_W-1:0]       data_q [VC_ENTRIES];
  logic [LINE_W-1:0]       data_d [VC_ENTRIES];
  logic [PTR_W-1:0]        rr_q, rr_d;

  logic                    lk_valid_q, lk_valid_d;
  logic                    lk_hit_q, lk_hit_d;
  logic                    lk_dirty_q, lk_dirty_d;
  logic [LINE_W-1:0]       lk_data_q, lk_data_d;
  logic [PTR_W-1:0]        lk_idx_q, lk_idx_d;

  logic [TAG_W-1:0]        wb_tag_q, wb_tag_d;
  logic [LINE_W-1:0]       wb_data_q, wb_data_d;
  logic                    flush_done_q, flush_done_d;

  logic [TAG_W-1:0]        lk_tag, ins_tag;
  logic                    lk_match, ins_match, free_found, scan_found;
  logic [PTR_W-1:0]        lk_match_idx, ins_match_idx, free_idx, scan_idx;
  logic [PTR_W-1:0]        ins_tgt;
  logic                    ins_dirty;
  logic                    unused_offsets;

  assign lk_tag  = lookup_addr_i[ADDR_W-1:OFFSET_W];
  assign ins_tag = insert_addr_i[ADDR_W-1:OFFSET_W];
  assign unused_offsets = ^{lookup_addr_i[OFFSET_W-1:0], insert_addr_i[OFFSET_W-1:0]};

  // Associative searches over the current entry state. Walking from the top
  // index down lets the lowest matching index win.
  always_comb begin
    lk_match      = 1'b0;
    lk_match_idx  = '0;
    ins_match     = 1'b0;
    ins_match_idx = '0;
    free_found    = 1'b0;
    free_idx      = '0;
    scan_found    = 1'b0;
    scan_idx      = '0;
    for (int i = VC_ENTRIES - 1; i >= 0; i--) begin
      if (valid_q[i] && (tag_q[i] == lk_tag)) begin
        lk_match     = 1'b1;
        lk_match_idx = PTR_W'(i);
      end
      if (valid_q[i] && (tag_q[i] == ins_tag)) begin
        ins_match     = 1'b1;
        ins_match_idx = PTR_W'(i);
      end
      if (!valid_q[i]) begin
        free_found = 1'b1;
        free_idx   = PTR_W'(i);
      end
      if (valid_q[i] && dirty_q[i]) begin
        scan_found = 1'b1;
        scan_idx   = PTR_W'(i);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    dirty_d      = dirty_q;
    tag_d        = tag_q;
    data_d       = data_q;
    rr_d         = rr_q;
    wb_tag_d     = wb_tag_q;
    wb_data_d    = wb_data_q;
    flush_done_d = 1'b0;
    ins_tgt      = '0;
    ins_dirty    = 1'b0;

    // Lookup result reflects entry state before any update of this cycle.
    lk_valid_d = lookup_req_i;
    lk_hit_d   = lookup_req_i & lk_match;
    lk_data_d  = '0;
    lk_dirty_d = 1'b0;
    lk_idx_d   = lk_idx_q;
    if (lookup_req_i && lk_match) begin
      lk_data_d  = data_q[lk_match_idx];
      lk_dirty_d = dirty_q[lk_match_idx];
      lk_idx_d   = lk_match_idx;
    end

    // Take applies first so a same-cycle insert into that slot survives.
    if (take_i && lk_valid_q && lk_hit_q) begin
      valid_d[lk_idx_q] = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (flush_i) begin
          state_d = S_FLUSH_SCAN;
        end else if (insert_i) begin
          if (ins_match) begin
            ins_tgt   = ins_match_idx;
            ins_dirty = dirty_q[ins_match_idx] | insert_dirty_i;
          end else if (free_found) begin
            ins_tgt   = free_idx;
            ins_dirty = insert_dirty_i;
          end else begin
            ins_tgt   = rr_q;
            ins_dirty = insert_dirty_i;
            rr_d      = rr_q + PTR_W'(1);
            if (dirty_q[rr_q]) begin
              wb_tag_d  = tag_q[rr_q];
              wb_data_d = data_q[rr_q];
              state_d   = S_WB;
            end
          end
          valid_d[ins_tgt] = 1'b1;
          dirty_d[ins_tgt] = ins_dirty;
          tag_d[ins_tgt]   = ins_tag;
          data_d[ins_tgt]  = insert_data_i;
        end
      end
      S_WB: begin
        if (wb_ack_i) begin
          state_d = S_IDLE;
        end
      end
      S_FLUSH_SCAN: begin
        if (scan_found) begin
          wb_tag_d          = tag_q[scan_idx];
          wb_data_d         = data_q[scan_idx];
          valid_d[scan_idx] = 1'b0;
          dirty_d[scan_idx] = 1'b0;
          state_d           = S_FLUSH_WB;
        end else begin
          valid_d      = '0;
          dirty_d      = '0;
          flush_done_d = 1'b1;
          state_d      = S_IDLE;
        end
      end
      S_FLUSH_WB: begin
        if (wb_ack_i) begin
          state_d = S_FLUSH_SCAN;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      valid_q      <= '0;
      dirty_q      <= '0;
      rr_q         <= '0;
      lk_valid_q   <= 1'b0;
      lk_hit_q     <= 1'b0;
      lk_dirty_q   <= 1'b0;
      lk_data_q    <= '0;
      lk_idx_q     <= '0;
      wb_tag_q     <= '0;
      wb_data_q    <= '0;
      flush_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      dirty_q      <= dirty_d;
      rr_q         <= rr_d;
      lk_valid_q   <= lk_valid_d;
      lk_hit_q     <= lk_hit_d;
      lk_dirty_q   <= lk_dirty_d;
      lk_data_q    <= lk_data_d;
      lk_idx_q     <= lk_idx_d;
      wb_tag_q     <= wb_tag_d;
      wb_data_q    <= wb_data_d;
      flush_done_q <= flush_done_d;
    end
  end

  // Entry payload is qualified by valid_q, so it needs no reset.
  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

  assign lookup_valid_o = lk_valid_q;
  assign lookup_hit_o   = lk_hit_q;
  assign lookup_data_o  = lk_data_q;
  assign lookup_dirty_o = lk_dirty_q;
  assign insert_ready_o = (state_q == S_IDLE) && !flush_i;
  assign flush_done_o   = flush_done_q;
  assign wb_req_o       = (state_q == S_WB) || (state_q == S_FLUSH_WB);
  assign wb_addr_o      = {wb_tag_q, {OFFSET_W{1'b0}}};
  assign wb_data_o      = wb_data_q;

`ifdef VC_STATS_EN
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (flush_done_q) begin
      hit_cnt_d  = '0;
      miss_cnt_d = '0;
    end else if (lk_valid_q) begin
      if (lk_hit_q && (hit_cnt_q != 32'hFFFF_FFFF)) begin
        hit_cnt_d = hit_cnt_q + 32'd1;
      end
      if (!lk_hit_q && (miss_cnt_q != 32'hFFFF_FFFF)) begin
        miss_cnt_d = miss_cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
`endif

endmodule

// File: tb/tb_wb_victim_cache.sv
module tb_wb_victim_cache;

  localparam int ADDR_W = 32;
  localparam int LINE_W = 128;
  localparam int N      = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              lookup_req_i;
  logic [ADDR_W-1:0] lookup_addr_i;
  logic              lookup_valid_o;
  logic              lookup_hit_o;
  logic [LINE_W-1:0] lookup_data_o;
  logic              lookup_dirty_o;
  logic              take_i;
  logic              insert_i;
  logic [ADDR_W-1:0] insert_addr_i;
  logic [LINE_W-1:0] insert_data_i;
  logic              insert_dirty_i;
  logic              insert_ready_o;
  logic              flush_i;
  logic              flush_done_o;
  logic              wb_req_o;
  logic [ADDR_W-1:0] wb_addr_o;
  logic [LINE_W-1:0] wb_data_o;
  logic              wb_ack_i;
`ifdef VC_STATS_EN
  logic [31:0]       hit_cnt;
  logic [31:0]       miss_cnt;
`endif

  wb_victim_cache #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .VC_ENTRIES(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .lookup_req_i(lookup_req_i), .lookup_addr_i(lookup_addr_i),
    .lookup_valid_o(lookup_valid_o), .lookup_hit_o(lookup_hit_o),
    .lookup_data_o(lookup_data_o), .lookup_dirty_o(lookup_dirty_o),
    .take_i(take_i), .insert_i(insert_i), .insert_addr_i(insert_addr_i),
    .insert_data_i(insert_data_i), .insert_dirty_i(insert_dirty_i),
    .insert_ready_o(insert_ready_o), .flush_i(flush_i), .flush_done_o(flush_done_o),
    .wb_req_o(wb_req_o), .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o),
    .wb_ack_i(wb_ack_i)
`ifdef VC_STATS_EN
    , .hit_cnt_o(hit_cnt), .miss_cnt_o(miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;

  // Reference model: a set of line-aligned addresses with data and dirty
  // flags, placed in slots because slot choice decides which line is
  // displaced.
  bit                mv    [N];
  bit                md    [N];
  logic [ADDR_W-1:0] mline [N];
  logic [LINE_W-1:0] mdata [N];
  int                mptr;
  logic [ADDR_W-1:0] last_wb_addr;

  function automatic logic [ADDR_W-1:0] line_of(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:4], 4'h0};
  endfunction

  function automatic int m_find(input logic [ADDR_W-1:0] a);
    for (int i = 0; i < N; i++)
      if (mv[i] && mline[i] == line_of(a)) return i;
    return -1;
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < N; i++) begin
      mv[i] = 0; md[i] = 0;
    end
    mptr = 0;
  endfunction

  function automatic void m_insert(input logic [ADDR_W-1:0] a, input logic [LINE_W-1:0] d,
                                   input bit dirty, output bit wb_exp,
                                   output logic [ADDR_W-1:0] wb_a, output logic [LINE_W-1:0] wb_d);
    int slot;
    wb_exp = 0; wb_a = '0; wb_d = '0;
    slot = m_find(a);
    if (slot >= 0) begin
      md[slot]    = md[slot] | dirty;
      mdata[slot] = d;
      return;
    end
    for (int i = N - 1; i >= 0; i--)
      if (!mv[i]) slot = i;
    if (slot < 0) begin
      slot = mptr;
      mptr = (mptr + 1) % N;
      if (md[slot]) begin
        wb_exp = 1; wb_a = mline[slot]; wb_d = mdata[slot];
      end
    end
    mv[slot] = 1; md[slot] = dirty; mline[slot] = line_of(a); mdata[slot] = d;
  endfunction

  task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [LINE_W-1:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One operation cycle starting and ending at a falling edge.
  task automatic do_op(input bit ins, input logic [ADDR_W-1:0] ia, input logic [LINE_W-1:0] idata,
                       input bit idirty, input bit lk, input logic [ADDR_W-1:0] la,
                       input bit take, input bit stray_ack, input int ack_delay,
                       input bit leave_pending);
    int lidx;
    logic [LINE_W-1:0] lexp_d;
    bit lexp_dirty;
    bit wb_exp;
    logic [ADDR_W-1:0] wb_a;
    logic [LINE_W-1:0] wb_d;
    lidx = -1; lexp_d = '0; lexp_dirty = 0; wb_exp = 0; wb_a = '0; wb_d = '0;
    if (lk) begin
      lidx = m_find(la);
      if (lidx >= 0) begin
        lexp_d = mdata[lidx]; lexp_dirty = md[lidx];
      end
    end
    if (ins) begin
      chk("ins_ready", insert_ready_o, 1);
      m_insert(ia, idata, idirty, wb_exp, wb_a, wb_d);
    end
    insert_i = ins; insert_addr_i = ia; insert_data_i = idata; insert_dirty_i = idirty;
    lookup_req_i = lk; lookup_addr_i = la; wb_ack_i = stray_ack;
    @(negedge clk);
    insert_i = 0; lookup_req_i = 0; wb_ack_i = 0;
    chk("lk_valid", lookup_valid_o, lk);
    if (lk) begin
      chk("lk_hit", lookup_hit_o, lidx >= 0);
      chk("lk_data", lookup_data_o, lexp_d);
      chk("lk_dirty", lookup_dirty_o, lexp_dirty);
    end
    chk("wb_req", wb_req_o, wb_exp);
    if (wb_exp) begin
      chk("wb_addr", wb_addr_o, wb_a);
      chk("wb_data", wb_data_o, wb_d);
      chk("ready_in_wb", insert_ready_o, 0);
      last_wb_addr = wb_addr_o;
    end
    if (lk && take) begin
      take_i = 1;
      @(negedge clk);
      take_i = 0;
      if (lidx >= 0) mv[lidx] = 0;
      chk("lk_pulse", lookup_valid_o, 0);
    end
    if (wb_exp && !leave_pending) begin
      repeat (ack_delay) begin
        @(negedge clk);
        chk("wb_hold_req", wb_req_o, 1);
        chk("wb_hold_addr", wb_addr_o, wb_a);
        chk("wb_hold_ready", insert_ready_o, 0);
      end
      wb_ack_i = 1;
      @(negedge clk);
      wb_ack_i = 0;
      chk("wb_released", wb_req_o, 0);
      chk("ready_after_wb", insert_ready_o, 1);
    end
  endtask

  task automatic do_insert(input logic [ADDR_W-1:0] a, input logic [LINE_W-1:0] d, input bit dirty,
                           input int ack_delay);
    do_op(1, a, d, dirty, 0, '0, 0, 0, ack_delay, 0);
  endtask

  task automatic do_lookup(input logic [ADDR_W-1:0] a, input bit take);
    do_op(0, '0, '0, 0, 1, a, take, 0, 0, 0);
  endtask

  task automatic do_flush(output int pulses);
    int q[$];
    int n;
    pulses = 0;
    for (int i = 0; i < N; i++)
      if (mv[i] && md[i]) q.push_back(i);
    flush_i = 1;
    @(negedge clk);
    flush_i = 0;
    foreach (q[k]) begin
      n = 0;
      while (!wb_req_o && n < 10) begin
        @(negedge clk); n++;
      end
      chk("fl_wb_req", wb_req_o, 1);
      chk("fl_wb_addr", wb_addr_o, mline[q[k]]);
      chk("fl_wb_data", wb_data_o, mdata[q[k]]);
      wb_ack_i = 1;
      @(negedge clk);
      wb_ack_i = 0;
    end
    n = 0;
    while (!flush_done_o && n < 10) begin
      chk("fl_extra_wb", wb_req_o, 0);
      @(negedge clk); n++;
    end
    chk("fl_done", flush_done_o, 1);
    if (flush_done_o) pulses++;
    @(negedge clk);
    chk("fl_done_pulse", flush_done_o, 0);
    if (flush_done_o) pulses++;
    for (int i = 0; i < N; i++) begin
      mv[i] = 0; md[i] = 0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, vectors %0d", vectors);
    $fatal(1, "timeout");
  end

  initial begin
    int pulses;
    logic [LINE_W-1:0] da, db;
    logic [ADDR_W-1:0] ra, rb;
    int r;

    rst_n = 0; lookup_req_i = 0; lookup_addr_i = '0; take_i = 0; insert_i = 0;
    insert_addr_i = '0; insert_data_i = '0; insert_dirty_i = 0; flush_i = 0; wb_ack_i = 0;
    last_wb_addr = '0;
    m_reset();
    #12;
    chk("rst_lk_valid", lookup_valid_o, 0);
    chk("rst_lk_hit", lookup_hit_o, 0);
    chk("rst_lk_data", lookup_data_o, 0);
    chk("rst_ready", insert_ready_o, 1);
    chk("rst_flush_done", flush_done_o, 0);
    chk("rst_wb_req", wb_req_o, 0);
    chk("rst_wb_addr", wb_addr_o, 0);
    chk("rst_wb_data", wb_data_o, 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);

    // Four clean inserts, hit with a non-zero offset, then a miss.
    for (int k = 1; k <= 4; k++) do_insert(32'h1000 * k, rand_line(), 0, 0);
    do_lookup(32'h3004, 0);
    do_lookup(32'h5000, 0);

    // Make every entry dirty in place, then displace entry 0 with a 3-cycle ack.
    for (int k = 1; k <= 4; k++) do_insert(32'h1000 * k, rand_line(), 1, 0);
    do_insert(32'h5000, rand_line(), 0, 3);
    chk("dir_wb_addr", last_wb_addr, 32'h1000);
    do_lookup(32'h1000, 0);

    // Take frees a slot; next insert reuses it without write-back.
    do_lookup(32'h2000, 1);
    do_lookup(32'h2000, 0);
    do_insert(32'h6000, rand_line(), 1, 0);

    // Entries 1 and 3 dirty, 0 and 2 clean, then flush.
    do_lookup(32'h3000, 1);
    do_insert(32'h7000, rand_line(), 0, 0);
    do_flush(pulses);
    chk("fl_pulse_count", pulses, 1);
    for (int k = 1; k <= 7; k++) do_lookup(32'h1000 * k, 0);

    // Clean re-insert over a dirty copy of the same line.
    da = rand_line(); db = rand_line();
    do_insert(32'h2000, da, 1, 0);
    do_insert(32'h2008, db, 0, 0);
    do_lookup(32'h2000, 0);
    chk("merge_data", lookup_data_o, db);
    chk("merge_dirty", lookup_dirty_o, 1);

    // Randomised mix against the model.
    for (int it = 0; it < 250; it++) begin
      ra = 32'h1000 * $urandom_range(1, 8) + $urandom_range(0, 15);
      rb = 32'h1000 * $urandom_range(1, 8) + $urandom_range(0, 15);
      r  = $urandom_range(0, 19);
      if (r < 8)
        do_op(1, ra, rand_line(), 1'($urandom_range(0, 1)), 0, '0, 0,
              1'($urandom_range(0, 1)), $urandom_range(0, 3), 0);
      else if (r < 14)
        do_op(0, '0, '0, 0, 1, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 0);
      else if (r < 19)
        do_op(1, ra, rand_line(), 1'($urandom_range(0, 1)), 1, rb, 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), $urandom_range(0, 2), 0);
      else begin
        do_flush(pulses);
        chk("rnd_fl_pulses", pulses, 1);
      end
    end

    // Asynchronous reset while a write-back is outstanding.
    do_flush(pulses);
    for (int k = 0; k < 4; k++) do_insert(32'hA000 + 32'h1000 * k, rand_line(), 1, 0);
    do_op(1, 32'hE000, rand_line(), 1, 0, '0, 0, 0, 0, 1);
    chk("pre_rst_wb_req", wb_req_o, 1);
    #2;
    rst_n = 0;
    #1;
    chk("arst_wb_req", wb_req_o, 0);
    chk("arst_ready", insert_ready_o, 1);
    chk("arst_lk_valid", lookup_valid_o, 0);
    m_reset();
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    for (int k = 0; k < 5; k++) do_lookup(32'hA000 + 32'h1000 * k, 0);
    do_lookup(32'h1000, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
